power2round_inverse: RTL and testbench

- Streaming inverse of the keygen Power2Round stage. Takes (t1, encoded t0) coefficient pairs and rebuilds t = t1*2^13 + t0 mod Q, with Q = 8380417.
- Mode 1 outputs only t1*2^13 mod Q, for the sign/verify path where t0 is absent.
- Sits between the unpack/decode path and the NTT input. Has valid/ready backpressure on both sides and a 256-coefficient polynomial counter.

---
 rtl/power2round_inverse_pkg.sv | 21 ++
 rtl/mod_q_correct.sv | 24 ++
 rtl/power2round_inverse.sv | 81 ++++++++
 tb/tb_power2round_inverse.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/power2round_inverse_pkg.sv
// Shared Dilithium constants and stage bundle types for
// the Power2Round inverse pipeline.
package power2round_inverse_pkg;

  localparam int Q       = 8380417;
  localparam int D       = 13;
  localparam int T0_HALF = 4096;
  localparam int N_COEF  = 256;
  localparam int T1_W    = 10;
  localparam int T0_W    = 13;
  localparam int SUM_W   = 25;

  typedef logic signed [SUM_W-1:0] sum_t;

  typedef struct packed {
    logic valid;
    logic err;
    sum_t sum;
  } s1_t;

endpackage

// File: rtl/mod_q_correct.sv
// Single-step signed reduction into [0,Q-1]; input must lie
// in (-Q, 2Q).
module mod_q_correct
  import power2round_inverse_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  sum_t             x,
  output logic [WIDTH-1:0] y
);

  sum_t r;

  always_comb begin
    r = x;
    if (x < 0) begin
      r = x + sum_t'(Q);
    end else if (x >= sum_t'(Q)) begin
      r = x - sum_t'(Q);
    end
    y = WIDTH'(r);
  end

endmodule

// File: rtl/power2round_inverse.sv
// Streaming t = t1*2^D + t0 mod Q rebuild, two stages,
// global-enable backpressure and polynomial counter.
module power2round_inverse #(
  parameter int WIDTH  = 24,
  parameter int N_COEF = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_t1,
  input  logic [WIDTH-1:0] i_t0,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_t,
  output logic             o_last,
  output logic             o_err
);

  import power2round_inverse_pkg::*;

  localparam int CW = (N_COEF > 1) ? $clog2(N_COEF) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_COEF - 1);

  logic             en;
  s1_t              s1_d;
  s1_t              s1_q;
  sum_t             hi;
  sum_t             lo;
  logic [WIDTH-1:0] t_red;
  logic [CW-1:0]    cnt_q;

  assign en      = !o_valid || i_ready;
  assign o_ready = en;
  assign o_last  = o_valid && (cnt_q == LAST);

  // out-of-range upper bits are flagged, then masked off
  always_comb begin
    s1_d       = '0;
    hi         = sum_t'(i_t1[T1_W-1:0]) <<< D;
    lo         = '0;
    if (!i_mode) begin
      lo = sum_t'(T0_HALF) - sum_t'(i_t0[T0_W-1:0]);
    end
    s1_d.valid = i_valid;
    s1_d.sum   = hi + lo;
    s1_d.err   = (|i_t1[WIDTH-1:T1_W]) ||
                 (!i_mode && (|i_t0[WIDTH-1:T0_W]));
  end

  mod_q_correct #(
    .WIDTH (WIDTH)
  ) u_red (
    .x (s1_q.sum),
    .y (t_red)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      o_valid <= 1'b0;
      o_t     <= '0;
      o_err   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (en) begin
        s1_q    <= s1_d;
        o_valid <= s1_q.valid;
        if (s1_q.valid) begin
          o_t   <= t_red;
          o_err <= s1_q.err;
        end
      end
      if (o_valid && i_ready) begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_power2round_inverse.sv
// Bench for power2round_inverse: arithmetic model with
// per-cycle compare, literal vectors, streams and resets.
module tb_power2round_inverse;

  localparam int W  = 24;
  localparam int QM = 8380417;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_mode = 1'b0;
  logic         i_ready = 1'b0;
  logic [W-1:0] i_t1 = '0;
  logic [W-1:0] i_t0 = '0;
  logic         o_ready;
  logic         o_valid;
  logic         o_last;
  logic         o_err;
  logic [W-1:0] o_t;

  always #5 clk = ~clk;

  power2round_inverse #(
    .WIDTH  (W),
    .N_COEF (256)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mode  (i_mode),
    .i_t1    (i_t1),
    .i_t0    (i_t0),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_t     (o_t),
    .o_last  (o_last),
    .o_err   (o_err)
  );

  typedef struct {
    int t;
    bit err;
    int lt;
    int le;
    int acc;
    bit seen;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   out_cnt = 0;
  int   n_last = 0;
  int   cyc = 0;
  int   pend_t = -1;
  int   pend_e = 0;

  task automatic chk(string n, longint got, longint exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  function automatic int model_t(int t1, int t0, bit m);
    int s;
    s = (t1 % 1024) * 8192 + (m ? 0 : 4096 - (t0 % 8192));
    s = s % QM;
    if (s < 0) s = s + QM;
    return s;
  endfunction

  function automatic bit model_e(int t1, int t0, bit m);
    return (t1 > 1023) || (!m && t0 > 8191);
  endfunction

  // compare process: every output-valid cycle, plus input capture
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    cyc++;
    if (rst_n) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL spurious_valid: got o_t %0d expected no output", o_t);
        end else begin
          chk("o_t", o_t, q[0].t);
          chk("o_err", o_err, q[0].err);
          chk("o_last", o_last, (out_cnt % 256) == 255);
          if (q[0].lt >= 0 && !q[0].seen) begin
            chk("lit_t", o_t, q[0].lt);
            chk("lit_err", o_err, q[0].le);
            chk("latency", cyc - q[0].acc, 2);
          end
          q[0].seen = 1'b1;
          if (i_ready) begin
            if (o_last) n_last++;
            void'(q.pop_front());
            out_cnt++;
          end
        end
      end else begin
        chk("o_last_idle", o_last, 0);
      end
      if (i_valid && o_ready) begin
        e.t    = model_t(int'(i_t1), int'(i_t0), i_mode);
        e.err  = model_e(int'(i_t1), int'(i_t0), i_mode);
        e.lt   = pend_t;
        e.le   = pend_e;
        e.acc  = cyc;
        e.seen = 1'b0;
        q.push_back(e);
      end
    end
  end

  task automatic send_lit(bit m, int t1, int t0, int et, int ee);
    @(negedge clk);
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_mode  = m;
    i_t1    = W'(t1);
    i_t0    = W'(t0);
    pend_t  = et;
    pend_e  = ee;
    @(negedge clk);
    i_valid = 1'b0;
    pend_t  = -1;
  endtask

  task automatic drain();
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    #3;
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #4;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    q.delete();
    out_cnt = 0;
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_last", o_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stream(int n);
    int sent = 0;
    bit have = 0;
    int guard = 0;
    while (sent < n && guard < 20 * n) begin
      @(negedge clk);
      guard++;
      i_ready = ($urandom % 3) != 0;
      if (!have) begin
        if ($urandom % 5 == 0) begin
          i_valid = 1'b0;
        end else begin
          i_mode  = ($urandom % 4) == 0;
          i_t1    = ($urandom % 16 == 0) ? W'($urandom_range(1024, 16777215))
                                         : W'($urandom_range(0, 1023));
          i_t0    = ($urandom % 16 == 0) ? W'($urandom_range(8192, 16777215))
                                         : W'($urandom_range(0, 8191));
          i_valid = 1'b1;
          have    = 1'b1;
        end
      end
      #1;
      if (i_valid && o_ready) begin
        sent++;
        have = 1'b0;
      end
    end
    chk("stream_sent", sent, n);
  endtask

  initial begin
    #1;
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o_t", o_t, 0);
    chk("reset_o_last", o_last, 0);
    chk("reset_o_err", o_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_o_ready", o_ready, 1);

    send_lit(0, 151, 6521, 1234567, 0);
    send_lit(0, 0, 4096, 0, 0);
    send_lit(0, 1, 8191, 4097, 0);
    send_lit(0, 0, 8191, 8376322, 0);
    send_lit(0, 1023, 0, 4095, 0);
    send_lit(1, 1023, 'h123, 8380416, 0);
    send_lit(1, 1, 0, 8192, 0);
    send_lit(0, 1024, 4096, 0, 1);
    send_lit(0, 5, 8192, 45056, 1);
    send_lit(1, 2, 9000, 16384, 0);
    drain();

    do_reset();
    stream(256);
    stream(256);
    drain();
    chk("last_after_two_polys", n_last, 2);

    // fill both stages, stall, then reset mid-stream
    @(negedge clk);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_mode  = 1'b0;
    i_t1    = W'(77);
    i_t0    = W'(100);
    repeat (4) @(negedge clk);
    chk("full_o_valid", o_valid, 1);
    chk("full_o_ready", o_ready, 0);
    do_reset();

    stream(256);
    drain();
    chk("last_after_reset_poly", n_last, 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
